// File: rtl/spi_pwm_config.sv
// spi_pwm_config
//   SPI mode-0 target that receives 16-bit register-write frames from a host
//   and holds the five PWM configuration registers.
//   Frame: bit15 = R/W (1 = write), bits14:8 = address, bits7:0 = data,
//   MSB first, sampled on the rising edge of sclk.
//
// Optional feature macro: SPI_READBACK_EN
//   When defined, adds output cipo. A read frame (bit15 = 0) returns the
//   addressed register on cipo, MSB first, after the 8 header bits.
//   Addresses above MAX_ADDR read as 0x00.
//
// Ports:
//   clk             system clock
//   rst             asynchronous reset, active-high
//   sclk, ncs, copi SPI pins, asynchronous to clk
//   en_reg_out_7_0  register 0x00
//   en_reg_out_15_8 register 0x01
//   en_reg_pwm_7_0  register 0x02
//   en_reg_pwm_15_8 register 0x03
//   pwm_duty_cycle  register 0x04
//   commit          one-clk strobe when a write is applied
//   frame_err       one-clk strobe when a frame of the wrong length is dropped
//   cipo            (SPI_READBACK_EN only) SPI data target->host
module spi_pwm_config #(
    parameter int SYNC_STAGES = 2,
    parameter int MAX_ADDR    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sclk,
    input  logic       ncs,
    input  logic       copi,
    output logic [7:0] en_reg_out_7_0,
    output logic [7:0] en_reg_out_15_8,
    output logic [7:0] en_reg_pwm_7_0,
    output logic [7:0] en_reg_pwm_15_8,
    output logic [7:0] pwm_duty_cycle,
    output logic       commit,
    output logic       frame_err
`ifdef SPI_READBACK_EN
    ,
    output logic       cipo
`endif
);

    localparam int NUM_REGS = 5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronizers (reset to the idle pin levels) and edge detect
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_ncs_sync;
    logic [SYNC_STAGES-1:0] r_copi_sync;
    logic                   r_sclk_d;
    logic                   r_ncs_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sclk_sync <= '0;
            r_ncs_sync  <= '1;
            r_copi_sync <= '0;
            r_sclk_d    <= 1'b0;
            r_ncs_d     <= 1'b1;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
            r_ncs_sync  <= {r_ncs_sync[SYNC_STAGES-2:0], ncs};
            r_copi_sync <= {r_copi_sync[SYNC_STAGES-2:0], copi};
            r_sclk_d    <= r_sclk_sync[SYNC_STAGES-1];
            r_ncs_d     <= r_ncs_sync[SYNC_STAGES-1];
        end
    end

    logic w_sclk_s, w_ncs_s, w_copi_s;
    logic w_sclk_rise, w_ncs_fall, w_ncs_rise;

    assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
    assign w_ncs_s     = r_ncs_sync[SYNC_STAGES-1];
    assign w_copi_s    = r_copi_sync[SYNC_STAGES-1];
    assign w_sclk_rise = w_sclk_s & ~r_sclk_d;
    assign w_ncs_fall  = ~w_ncs_s & r_ncs_d;
    assign w_ncs_rise  = w_ncs_s & ~r_ncs_d;

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    state_t r_state, w_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_ncs_fall) w_next = SHIFT;
            SHIFT:   if (w_ncs_rise) w_next = COMMIT;
            COMMIT:  w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Shift register and bit counter. The counter stops at 17 so any
    // over-long frame stays distinguishable from a 16-bit one.
    // ------------------------------------------------------------------
    logic [15:0] r_shift;
    logic [4:0]  r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_shift <= '0;
                    r_cnt   <= '0;
                end
                SHIFT: begin
                    if (w_sclk_rise) begin
                        r_shift <= {r_shift[14:0], w_copi_s};
                        if (r_cnt != 5'd17) r_cnt <= r_cnt + 5'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    logic [6:0] w_addr;
    logic       w_len_ok;
    logic       w_addr_ok;
    logic       w_wr_ok;

    assign w_addr    = r_shift[14:8];
    assign w_len_ok  = (r_cnt == 5'd16);
    assign w_addr_ok = (int'(w_addr) <= MAX_ADDR);
    assign w_wr_ok   = (r_state == COMMIT) && w_len_ok && r_shift[15] && w_addr_ok;

    // ------------------------------------------------------------------
    // Configuration registers and strobes
    // ------------------------------------------------------------------
    logic [7:0] r_regs [NUM_REGS];
    logic       r_commit;
    logic       r_frame_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= 8'h00;
            r_commit    <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_commit    <= w_wr_ok;
            r_frame_err <= (r_state == COMMIT) && !w_len_ok;
            if (w_wr_ok) begin
                for (int i = 0; i < NUM_REGS; i++)
                    if (w_addr == 7'(i)) r_regs[i] <= r_shift[7:0];
            end
        end
    end

    assign en_reg_out_7_0  = r_regs[0];
    assign en_reg_out_15_8 = r_regs[1];
    assign en_reg_pwm_7_0  = r_regs[2];
    assign en_reg_pwm_15_8 = r_regs[3];
    assign pwm_duty_cycle  = r_regs[4];
    assign commit          = r_commit;
    assign frame_err       = r_frame_err;

`ifdef SPI_READBACK_EN
    // ------------------------------------------------------------------
    // Readback. After 8 header bits r_shift[7:0] holds {R/W, addr}. The
    // falling edge that follows the 8th rising edge drives the register
    // MSB; the remaining bits follow on the next seven falling edges.
    // ------------------------------------------------------------------
    logic       w_sclk_fall;
    logic [7:0] w_rd_val;
    logic [7:0] r_tx;
    logic       r_rd_act;
    logic       r_cipo;

    assign w_sclk_fall = ~w_sclk_s & r_sclk_d;

    always_comb begin
        w_rd_val = 8'h00;
        if (int'(r_shift[6:0]) <= MAX_ADDR) begin
            for (int i = 0; i < NUM_REGS; i++)
                if (r_shift[6:0] == 7'(i)) w_rd_val = r_regs[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx     <= 8'h00;
            r_rd_act <= 1'b0;
            r_cipo   <= 1'b0;
        end else if (w_ncs_s || r_state != SHIFT) begin
            r_tx     <= 8'h00;
            r_rd_act <= 1'b0;
            r_cipo   <= 1'b0;
        end else if (w_sclk_fall) begin
            if (r_cnt == 5'd8 && !r_shift[7]) begin
                r_rd_act <= 1'b1;
                r_cipo   <= w_rd_val[7];
                r_tx     <= {w_rd_val[6:0], 1'b0};
            end else if (r_rd_act && r_cnt > 5'd8 && r_cnt < 5'd16) begin
                r_cipo   <= r_tx[7];
                r_tx     <= {r_tx[6:0], 1'b0};
            end else begin
                r_rd_act <= 1'b0;
                r_cipo   <= 1'b0;
            end
        end
    end

    assign cipo = r_cipo;
`endif

endmodule

// File: tb/tb_spi_pwm_config.sv
module tb_spi_pwm_config;

    localparam int MAX_ADDR = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       sclk;
    logic       ncs;
    logic       copi;
    logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle;
    logic       commit;
    logic       frame_err;
`ifdef SPI_READBACK_EN
    logic       cipo;
`endif

    spi_pwm_config #(.SYNC_STAGES(2), .MAX_ADDR(MAX_ADDR)) dut (
        .clk             (clk),
        .rst             (rst),
        .sclk            (sclk),
        .ncs             (ncs),
        .copi            (copi),
        .en_reg_out_7_0  (en_reg_out_7_0),
        .en_reg_out_15_8 (en_reg_out_15_8),
        .en_reg_pwm_7_0  (en_reg_pwm_7_0),
        .en_reg_pwm_15_8 (en_reg_pwm_15_8),
        .pwm_duty_cycle  (pwm_duty_cycle),
        .commit          (commit),
        .frame_err       (frame_err)
`ifdef SPI_READBACK_EN
        ,
        .cipo            (cipo)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // strobe counters observed from the DUT
    int n_commit = 0;
    int n_ferr   = 0;

    always @(negedge clk) begin
        if (commit === 1'b1)    n_commit++;
        if (frame_err === 1'b1) n_ferr++;
    end

    // reference model: register image plus expected strobe counts
    logic [7:0] m_regs [5];
    int         m_commit = 0;
    int         m_ferr   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] dut_reg(input int i);
        case (i)
            0:       return en_reg_out_7_0;
            1:       return en_reg_out_15_8;
            2:       return en_reg_pwm_7_0;
            3:       return en_reg_pwm_15_8;
            default: return pwm_duty_cycle;
        endcase
    endfunction

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < 5; i++) chk($sformatf("%s_reg%0d", tag, i), dut_reg(i), m_regs[i]);
        chk({tag, "_ncommit"}, n_commit, m_commit);
        chk({tag, "_nferr"}, n_ferr, m_ferr);
    endtask

    // Shift nbits onto the bus: bits 0..15 come from w (MSB first), any
    // further bits are 'extra'. Model is updated when ncs rises.
    task automatic send_frame(input logic [15:0] w, input int nbits, input logic extra,
                              input bit chk_lat, input bit chk_rd);
        logic [7:0] rd_got;
        logic [7:0] rd_exp;
        logic [7:0] old_v;
        logic [7:0] new_v;
        int         a;
        bit         wr;
        rd_got = 8'h00;
        a      = int'(w[14:8]);
        rd_exp = (a <= MAX_ADDR && a < 5) ? m_regs[a] : 8'h00;
        @(negedge clk);
        ncs = 1'b0;
        wait_clk(5);
        for (int i = 0; i < nbits; i++) begin
            copi = (i < 16) ? w[15-i] : extra;
            wait_clk(5);
`ifdef SPI_READBACK_EN
            if (i >= 8 && i < 16) rd_got[15-i] = cipo;
`endif
            sclk = 1'b1;
            wait_clk(5);
            sclk = 1'b0;
        end
        wait_clk(5);
        copi = 1'b0;
        ncs  = 1'b1;
        wr   = (nbits == 16) && w[15] && (a <= MAX_ADDR);
        old_v = (a < 5) ? m_regs[a] : 8'h00;
        new_v = wr ? w[7:0] : old_v;
        if (nbits != 16) m_ferr++;
        else if (wr) begin
            m_regs[a] = w[7:0];
            m_commit++;
        end
        if (chk_lat) begin
            repeat (3) @(posedge clk);
            #1;
            chk("lat_edge3_val", dut_reg(a), old_v);
            chk("lat_edge3_commit", commit, 1'b0);
            @(posedge clk);
            #1;
            chk("lat_edge4_val", dut_reg(a), new_v);
            chk("lat_edge4_commit", commit, wr);
        end
        wait_clk(8);
`ifdef SPI_READBACK_EN
        if (chk_rd) chk($sformatf("readback_%04h", w), rd_got, rd_exp);
        chk("cipo_idle", cipo, 1'b0);
`else
        if (chk_rd) chk($sformatf("rd_nochange_%04h", w), dut_reg(a < 5 ? a : 0), m_regs[a < 5 ? a : 0]);
`endif
    endtask

    initial begin
        logic [15:0] w;
        int          nb;
        for (int i = 0; i < 5; i++) m_regs[i] = 8'h00;
        rst  = 1'b1;
        sclk = 1'b0;
        ncs  = 1'b1;
        copi = 1'b0;
        wait_clk(4);
        rst = 1'b0;
        wait_clk(6);
        check_all("reset");
        chk("reset_commit", commit, 1'b0);
        chk("reset_ferr", frame_err, 1'b0);

        // single write with latency check
        send_frame(16'h8055, 16, 1'b0, 1'b1, 1'b0);
        check_all("wr_8055");

        // back-to-back writes
        send_frame(16'h84C0, 16, 1'b0, 1'b1, 1'b0);
        send_frame(16'h8201, 16, 1'b0, 1'b0, 1'b0);
        check_all("b2b");

        // out-of-range write and a read frame
        send_frame(16'h85FF, 16, 1'b0, 1'b0, 1'b0);
        check_all("oor");
        send_frame(16'h0000, 16, 1'b0, 1'b0, 1'b1);
        check_all("rd0000");

        // bad lengths
        send_frame(16'h8377, 15, 1'b0, 1'b0, 1'b0);
        check_all("len15");
        send_frame(16'h8377, 17, 1'b1, 1'b0, 1'b0);
        check_all("len17");

        // reset mid-frame after 9 bits of 0x81AA
        w = 16'h81AA;
        @(negedge clk);
        ncs = 1'b0;
        wait_clk(5);
        for (int i = 0; i < 9; i++) begin
            copi = w[15-i];
            wait_clk(5);
            sclk = 1'b1;
            wait_clk(5);
            sclk = 1'b0;
        end
        rst = 1'b1;
        wait_clk(2);
        ncs  = 1'b1;
        copi = 1'b0;
        wait_clk(2);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) m_regs[i] = 8'h00;
        wait_clk(10);
        check_all("midrst");

        send_frame(16'h81AA, 16, 1'b0, 1'b1, 1'b0);
        check_all("wr_81aa");
        send_frame(16'h0100, 16, 1'b0, 1'b0, 1'b1);
        check_all("rd_0100");

        // sclk toggling while deselected must be ignored
        for (int i = 0; i < 12; i++) begin
            copi = 1'($urandom_range(0, 1));
            wait_clk(5);
            sclk = ~sclk;
        end
        sclk = 1'b0;
        copi = 1'b0;
        wait_clk(10);
        check_all("idle_sclk");

        // randomized frames
        for (int k = 0; k < 36; k++) begin
            w[15]   = ($urandom_range(0, 3) != 0);
            w[14:8] = 7'($urandom_range(0, 6));
            w[7:0]  = 8'($urandom);
            case ($urandom_range(0, 7))
                0:       nb = 15;
                1:       nb = 17;
                2:       nb = $urandom_range(1, 14);
                default: nb = 16;
            endcase
            send_frame(w, nb, 1'($urandom_range(0, 1)), 1'b0, (nb >= 16) && !w[15]);
            check_all($sformatf("rnd%0d", k));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_pwm_config.md
Name: spi_pwm_config

Overview:
- SPI target (mode 0: CPOL=0, CPHA=0) that receives register writes from an external host and holds the PWM peripheral's configuration registers.
- Drives en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8 and pwm_duty_cycle into pwm_peripheral.
- Sits between the top-level ui_in pins (SCLK, COPI, nCS) and the PWM datapath.
- Fully synchronous to clk; the SPI pins are sampled through synchronizers.

Parameters:
SYNC_STAGES, 2, flip-flop stages on each SPI input (legal range ≥2)
MAX_ADDR, 4, highest writable register address; frames addressed above this are ignored

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-high
sclk  input  1  SPI clock, asynchronous to clk
ncs  input  1  SPI chip select, active-low, asynchronous
copi  input  1  SPI data host->target, asynchronous
en_reg_out_7_0  output  8  register 0x00
en_reg_out_15_8  output  8  register 0x01
en_reg_pwm_7_0  output  8  register 0x02
en_reg_pwm_15_8  output  8  register 0x03
pwm_duty_cycle  output  8  register 0x04
commit  output  1  one-clk strobe when a write is applied
frame_err  output  1  one-clk strobe when a frame is discarded for bad length

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous and active-high.
- Reset: all five registers = 0x00; commit=0; frame_err=0; state=IDLE; bit counter=0; shift register=0; all synchronizers = idle levels (sclk=0, ncs=1, copi=0).
- Synchronization: sclk, ncs and copi each pass through SYNC_STAGES flops.
  - Edges are detected on the synchronized copy against a one-flop-delayed copy.
  - The system guarantees sclk high and low phases are each ≥4 clk periods.
- Frame format: 16 bits, MSB first, sampled on sclk rising edge.
  - bit15 = R/W (1 = write).
  - bits14:8 = 7-bit address.
  - bits7:0 = data.
- FSM:
  - IDLE: shift register and counter cleared. Go to SHIFT on synchronized ncs falling edge.
  - SHIFT: on each synchronized sclk rising edge, shift in copi and increment the counter. The counter saturates at 17, which marks overflow. Go to COMMIT on synchronized ncs rising edge.
  - COMMIT: one cycle. If count==16, R/W=1 and addr≤MAX_ADDR, write data to the addressed register and pulse commit. If count≠16, pulse frame_err with no write. If count==16 and the frame is a read, or the address is out of range, pulse neither and write nothing. Then return to IDLE.
- Latency: registers and commit update on the clk edge after COMMIT is entered. With SYNC_STAGES=2, new register values are visible 4 clk edges after the first edge that samples ncs=1.
- sclk edges while ncs is high (IDLE) are ignored.
- An ncs rising and falling edge within the same frame boundary cannot occur, given the guaranteed pulse widths.
- rst asserted mid-frame: all state and registers clear immediately. A partial frame continuing after rst deasserts is still in SHIFT only if a new ncs falling edge is seen; otherwise it is ignored.
- Registers not addressed by a write hold their values. Back-to-back frames are each committed independently.
- Outputs are registered, with no combinational path from SPI pins.

Optional Feature:
SPI_READBACK_EN
- Defined:
  - Adds output port cipo (1 bit, reset 0).
  - On a read frame (bit15=0) with addr≤MAX_ADDR: after the 8th header bit, each synchronized sclk falling edge drives the next register bit onto cipo, MSB first. cipo is updated on the clk edge after the edge is detected.
  - Out-of-range read returns 0x00.
  - cipo=0 whenever ncs is high.
- Not defined: no cipo port; read frames are accepted and ignored; no readback logic is synthesized.

Test Plan:
- Reset, then idle pins -> all five registers 0x00, commit=0, frame_err=0.
- Write frame 0x8055 (addr 0, data 0x55) -> en_reg_out_7_0=0x55 at the 4th clk edge after ncs high; single commit pulse; others still 0x00.
- Writes 0x84C0 then 0x8201 back-to-back -> pwm_duty_cycle=0xC0, en_reg_pwm_7_0=0x01, two commit pulses.
- Write to addr 0x05 (frame 0x85FF) -> no register change, no commit, no frame_err. Read frame 0x0000 -> no change.
- 15-bit frame, then 17-bit frame -> frame_err pulses once for each, registers unchanged.
- rst pulsed after 9 bits of frame 0x81AA -> registers 0x00. Next full frame 0x81AA -> en_reg_out_15_8=0xAA. With SPI_READBACK_EN, read frame 0x0100 -> cipo shifts 0xAA MSB first.
